// File: rtl/iterative_row_multiplier.sv
// -----------------------------------------------------------------------------
// iterative_row_multiplier
//
// Multi-cycle integer multiplier for the MUL/MULH/MULHSU/MULHU datapath. It
// works on operand magnitudes. Each clock adds one partial-product row (the
// multiplicand magnitude gated by one multiplier bit) into the upper half of a
// 2*DATA_WIDTH accumulator. The accumulator then shifts right by one, so one
// final product bit retires into the low half per row. A last cycle applies
// the result sign and registers the product.
//
// Optional feature, selected by the macro MUL_EARLY_EXIT_EN:
//   When defined, the row loop ends as soon as the remaining multiplier bits
//   are all zero. The accumulator is then shifted right by the number of
//   skipped rows so that the product bits are aligned correctly. Results are
//   bit-identical with and without the macro; only the latency changes.
//
// Parameters
//   DATA_WIDTH             operand width, power of 2, >= 4 (default 32)
//
// Ports
//   clk_i                  clock, rising edge
//   rst_i                  synchronous active-high reset
//   multiplicand_i         operand A
//   multiplier_i           operand B
//   multiplicand_signed_i  A is two's complement
//   multiplier_signed_i    B is two's complement
//   data_valid_i           operands present, taken when ready_o=1
//   kill_i                 abort in-flight operation / block acceptance
//   ready_o                idle, able to accept
//   product_o              full 2*DATA_WIDTH product, held until next result
//   data_valid_o           one-cycle pulse, product_o is new
// -----------------------------------------------------------------------------
module iterative_row_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     multiplicand_i,
  input  logic [DATA_WIDTH-1:0]     multiplier_i,
  input  logic                      multiplicand_signed_i,
  input  logic                      multiplier_signed_i,
  input  logic                      data_valid_i,
  input  logic                      kill_i,
  output logic                      ready_o,
  output logic [2*DATA_WIDTH-1:0]   product_o,
  output logic                      data_valid_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ROW = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLY,
    FINALIZE
  } state_t;

  state_t            state_reg, state_next;
  logic [W-1:0]      a_mag_reg, a_mag_next;
  logic [W-1:0]      b_mag_reg, b_mag_next;
  logic              sign_reg, sign_next;
  logic [2*W-1:0]    acc_reg, acc_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [2*W-1:0]    product_reg, product_next;
  logic              valid_reg, valid_next;

  // Operand magnitudes. Negating 0x80..0 in W bits gives 0x80..0 again,
  // which read as unsigned is exactly 2^(W-1), so no extra bit is needed.
  logic              neg_a, neg_b;
  logic [W-1:0]      a_mag_in, b_mag_in;

  assign neg_a    = multiplicand_signed_i & multiplicand_i[W-1];
  assign neg_b    = multiplier_signed_i & multiplier_i[W-1];
  assign a_mag_in = neg_a ? -multiplicand_i : multiplicand_i;
  assign b_mag_in = neg_b ? -multiplier_i : multiplier_i;

  // One row: gated multiplicand added into the upper half (W+1 bit result),
  // then the whole accumulator moves right by one.
  logic [W-1:0]      row_addend;
  logic [W:0]        row_sum;
  logic [2*W-1:0]    acc_row;
  logic [W-1:0]      b_shift;
  logic              last_row;

  assign row_addend = a_mag_reg & {W{b_mag_reg[0]}};
  assign row_sum    = {1'b0, acc_reg[2*W-1:W]} + {1'b0, row_addend};
  assign acc_row    = {row_sum, acc_reg[W-1:1]};
  assign b_shift    = b_mag_reg >> 1;
  assign last_row   = (cnt_reg == LAST_ROW);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      a_mag_reg   <= '0;
      b_mag_reg   <= '0;
      sign_reg    <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_mag_reg   <= a_mag_next;
      b_mag_reg   <= b_mag_next;
      sign_reg    <= sign_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_mag_next   = a_mag_reg;
    b_mag_next   = b_mag_reg;
    sign_next    = sign_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    valid_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (data_valid_i && !kill_i) begin
          a_mag_next = a_mag_in;
          b_mag_next = b_mag_in;
          sign_next  = neg_a ^ neg_b;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = MULTIPLY;
        end
      end

      MULTIPLY: begin
        if (kill_i) begin
          state_next = IDLE;
        end else begin
          acc_next   = acc_row;
          b_mag_next = b_shift;
          cnt_next   = cnt_reg + CW'(1);
          if (last_row) begin
            state_next = FINALIZE;
          end
`ifdef MUL_EARLY_EXIT_EN
          // No set bits left: the skipped rows would only add zero and
          // shift, so apply all of their shifts at once.
          else if (b_shift == '0) begin
            acc_next   = acc_row >> (LAST_ROW - cnt_reg);
            state_next = FINALIZE;
          end
`endif
        end
      end

      FINALIZE: begin
        state_next = IDLE;
        if (!kill_i) begin
          product_next = sign_reg ? -acc_reg : acc_reg;
          valid_next   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready_o      = (state_reg == IDLE);
  assign product_o    = product_reg;
  assign data_valid_o = valid_reg;

endmodule

// File: tb/tb_iterative_row_multiplier.sv
// -----------------------------------------------------------------------------
// tb_iterative_row_multiplier
//
// Directed, table-driven bench for iterative_row_multiplier (DATA_WIDTH=32).
// Vectors carry hand-computed products; the expected latency is derived from
// the operand B magnitude and whether MUL_EARLY_EXIT_EN is defined. Hand
// sequences cover back-to-back issue, kill, kill while idle and reset mid-op.
// -----------------------------------------------------------------------------
module tb_iterative_row_multiplier;

  localparam int W = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [W-1:0]    multiplicand_i;
  logic [W-1:0]    multiplier_i;
  logic            multiplicand_signed_i;
  logic            multiplier_signed_i;
  logic            data_valid_i;
  logic            kill_i;
  logic            ready_o;
  logic [2*W-1:0]  product_o;
  logic            data_valid_o;

  iterative_row_multiplier #(.DATA_WIDTH(W)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .multiplicand_i        (multiplicand_i),
    .multiplier_i          (multiplier_i),
    .multiplicand_signed_i (multiplicand_signed_i),
    .multiplier_signed_i   (multiplier_signed_i),
    .data_valid_i          (data_valid_i),
    .kill_i                (kill_i),
    .ready_o               (ready_o),
    .product_o             (product_o),
    .data_valid_o          (data_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sa;
    logic           sb;
    logic [2*W-1:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and move to a safe sampling point after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Edges from accept until data_valid_o is seen.
  function automatic int exp_latency(input logic [W-1:0] b, input logic sb);
    logic [W-1:0] mag;
    int k;
    mag = (sb && b[W-1]) ? -b : b;
    k = 0;
    for (int i = 0; i < W; i++) if (mag[i]) k = i;
`ifdef MUL_EARLY_EXIT_EN
    return k + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic watch_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (data_valid_o) pulses++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb,
                        output logic [2*W-1:0] prod, output int lat);
    multiplicand_i        = a;
    multiplier_i          = b;
    multiplicand_signed_i = sa;
    multiplier_signed_i   = sb;
    data_valid_i          = 1'b1;
    tick();
    data_valid_i = 1'b0;
    check("ready_low_after_accept", 64'(ready_o), 64'd0);
    lat = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (data_valid_o) break;
    end
    check("valid_seen", 64'(data_valid_o), 64'd1);
    prod = product_o;
    check("ready_in_valid_cycle", 64'(ready_o), 64'd1);
    tick();
    check("valid_single_pulse", 64'(data_valid_o), 64'd0);
    check("product_held", product_o, prod);
  endtask

  initial begin
    logic [2*W-1:0] prod;
    int lat;
    int gap;
    int pulses;

    vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 64'h0000_0000_8000_0000};
    vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001};
    vecs[3]  = '{32'h0000_0007, 32'h0000_0003, 1'b0, 1'b0, 64'd21};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 64'd0};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000};
    vecs[7]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000};
    vecs[8]  = '{32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[9]  = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE};
    vecs[11] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'h3FFF_FFFF_0000_0001};

    rst_i                 = 1'b1;
    multiplicand_i        = '0;
    multiplier_i          = '0;
    multiplicand_signed_i = 1'b0;
    multiplier_signed_i   = 1'b0;
    data_valid_i          = 1'b0;
    kill_i                = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(data_valid_o), 64'd0);
    check("reset_product", product_o, 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, prod, lat);
      check($sformatf("vec%0d_product", i), prod, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_latency(vecs[i].b, vecs[i].sb)));
      $display("op %0d: A=%h B=%h sa=%0d sb=%0d -> product=%h latency=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, prod, lat);
    end

    // Back-to-back: 3x4 then 5x6 accepted in the data_valid_o cycle.
    multiplicand_i        = 32'd3;
    multiplier_i          = 32'd4;
    multiplicand_signed_i = 1'b0;
    multiplier_signed_i   = 1'b0;
    data_valid_i          = 1'b1;
    tick();
    data_valid_i = 1'b0;
    lat = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (data_valid_o) break;
    end
    check("b2b_first_valid", 64'(data_valid_o), 64'd1);
    check("b2b_first_product", product_o, 64'd12);
    multiplicand_i = 32'd5;
    multiplier_i   = 32'd6;
    data_valid_i   = 1'b1;
    tick();
    data_valid_i = 1'b0;
    check("b2b_first_single_pulse", 64'(data_valid_o), 64'd0);
    check("b2b_second_accepted", 64'(ready_o), 64'd0);
    gap = 1;
    while (gap < 200) begin
      if (data_valid_o) break;
      tick();
      gap++;
    end
    check("b2b_second_valid", 64'(data_valid_o), 64'd1);
    check("b2b_second_product", product_o, 64'd30);
    check("b2b_pulse_spacing", 64'(gap), 64'(exp_latency(32'd6, 1'b0) + 1));
    tick();
    check("b2b_second_single_pulse", 64'(data_valid_o), 64'd0);
    $display("op b2b: 3x4=12 then 5x6=%0d, pulse spacing %0d", product_o, gap);

    // Kill at edge 5 after accept.
    multiplicand_i = 32'hFFFF_FFFF;
    multiplier_i   = 32'hFFFF_FFFF;
    data_valid_i   = 1'b1;
    tick();
    data_valid_i = 1'b0;
    repeat (4) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_ready", 64'(ready_o), 64'd1);
    check("kill_valid", 64'(data_valid_o), 64'd0);
    check("kill_product_unchanged", product_o, 64'd30);
    watch_pulses(40, pulses);
    check("kill_no_pulse", 64'(pulses), 64'd0);
    $display("op kill: aborted at edge 5, product=%h", product_o);

    // Kill while idle blocks acceptance.
    data_valid_i = 1'b1;
    kill_i       = 1'b1;
    tick();
    data_valid_i = 1'b0;
    kill_i       = 1'b0;
    check("idle_kill_not_accepted", 64'(ready_o), 64'd1);
    watch_pulses(40, pulses);
    check("idle_kill_no_pulse", 64'(pulses), 64'd0);
    $display("op idle_kill: acceptance blocked, ready=%0d", ready_o);

    // Reset at edge 10 after accept.
    data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midop_reset_ready", 64'(ready_o), 64'd1);
    check("midop_reset_valid", 64'(data_valid_o), 64'd0);
    check("midop_reset_product", product_o, 64'd0);
    watch_pulses(40, pulses);
    check("midop_reset_no_pulse", 64'(pulses), 64'd0);
    $display("op reset: mid-operation reset, product=%h", product_o);

    // Recovery after reset.
    run_op(32'd7, 32'd3, 1'b0, 1'b0, prod, lat);
    check("post_reset_product", prod, 64'd21);
    check("post_reset_latency", 64'(lat), 64'(exp_latency(32'd3, 1'b0)));
    $display("op post_reset: 7x3 -> product=%h latency=%0d", prod, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_row_multiplier.md
# iterative_row_multiplier

Multi-cycle integer multiplier that feeds one partial-product row per clock into a row accumulator. Each row adds the multiplicand, gated by one multiplier bit, into the running partial product and retires one final product bit. It sits in the integer execution unit beside the combinational array multiplier, and serves the area-constrained configuration of the MUL/MULH/MULHSU/MULHU datapath. It uses a simple valid/ready handshake and produces one full-width product per accepted operation.

## Interface
- DATA_WIDTH, 32, operand width in bits; must be a power of 2, minimum 4.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- multiplicand_i  input  DATA_WIDTH  operand A.
- multiplier_i  input  DATA_WIDTH  operand B.
- multiplicand_signed_i  input  1  treat A as two's complement.
- multiplier_signed_i  input  1  treat B as two's complement.
- data_valid_i  input  1  operands present; accepted when ready_o=1.
- kill_i  input  1  abort the in-flight operation (pipeline flush).
- ready_o  output  1  block idle and able to accept.
- product_o  output  2*DATA_WIDTH  full product, two's complement if either operand is signed.
- data_valid_o  output  1  single-cycle pulse; product_o is valid.

## Operation
- States:
  - IDLE: ready_o=1.
  - MULTIPLY: one row per cycle.
  - FINALIZE: sign fix and output register.
- Accept: on an edge with state=IDLE, data_valid_i=1 and kill_i=0:
  - Register the magnitudes of A and B. For a signed operand with the MSB set, the magnitude is its DATA_WIDTH-bit negation; 0x80..0 yields magnitude 2^(DATA_WIDTH-1).
  - Register the result sign: neg_A XOR neg_B.
  - Clear the accumulator and the row counter, then go to MULTIPLY.
- MULTIPLY, per edge, for row i (0..DATA_WIDTH-1):
  - Add (|A| AND {DATA_WIDTH{|B|[i]}}) to the upper DATA_WIDTH+1 accumulator bits.
  - Shift the accumulator right by 1, with the retired LSB entering the low product half.
  - Shift the multiplier register right by 1 and increment the counter.
  - After row DATA_WIDTH-1, go to FINALIZE.
- FINALIZE, one edge:
  - product_o <= sign ? -acc : acc, as a 2*DATA_WIDTH-bit two's complement.
  - data_valid_o <= 1.
  - Go to IDLE.
- data_valid_o is high only in the first cycle back in IDLE. product_o holds its value until the next FINALIZE or until reset.
- Back-to-back: a new operation may be accepted in the same cycle data_valid_o is high.
- kill_i=1 in MULTIPLY or FINALIZE:
  - Next state is IDLE.
  - No data_valid_o pulse; product_o is unchanged.
  - kill_i in IDLE blocks acceptance.
- data_valid_i while ready_o=0 is ignored; the producer must hold its operands.
- Arithmetic is exact for all operand pairs and sign modes; there is no overflow.

## Timing
- Reset (rst_i=1 at an edge), from any state including mid-operation:
  - state=IDLE, ready_o=1, data_valid_o=0, product_o=0.
  - Accumulator, counter and operand registers cleared.
  - The in-flight operation is discarded.
- Latency without early exit: accept at edge 0, rows at edges 1..DATA_WIDTH, FINALIZE at edge DATA_WIDTH+1. data_valid_o is high in the cycle after edge DATA_WIDTH+1.
- ready_o is low from the cycle after accept until the cycle after FINALIZE.
- Throughput: one operation per DATA_WIDTH+2 cycles.
- Priority: rst_i > kill_i > accept.

## Configuration
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In MULTIPLY, if the multiplier register after the current shift is zero, go to FINALIZE immediately.
  - The accumulator is then shifted right by the remaining row count so the alignment is correct.
  - Latency becomes k+2 edges, where k is the index of the highest set bit of |B|. With |B|=0, k=0 and latency is 2.
- Undefined: always DATA_WIDTH rows, fixed latency DATA_WIDTH+1. No shift-alignment logic is generated.
- Results are bit-identical with and without the macro.

## Test plan
- Unsigned corner (DATA_WIDTH=32): A=B=0xFFFFFFFF, unsigned, macro off -> product_o=0xFFFFFFFE00000001, data_valid_o after edge 33.
- Signed extremes: A=0xFFFFFFFF, B=0x80000000, both signed -> product_o=0x0000000080000000.
- Mixed sign: A=0xFFFFFFFF signed, B=0xFFFFFFFF unsigned -> product_o=0xFFFFFFFF00000001.
- Early exit: A=7, B=3 unsigned:
  - Macro on -> product_o=21, valid after edge 3.
  - Macro on, B=0 -> product_o=0 after edge 2.
  - Macro off -> product_o=21 after edge 33.
- Abort:
  - kill_i at edge 5 after accept -> no data_valid_o, ready_o=1 next cycle, product_o unchanged.
  - rst_i at edge 10 -> all outputs at reset values.
- Back-to-back: second operation (5×6) accepted in the data_valid_o cycle of the first (3×4) -> products 12 then 30, each as a single-cycle pulse, DATA_WIDTH+2 cycles apart.
